// File: rtl/iq_frame_buffer_if.sv
// iq_frame_buffer_if: streaming bus between a sample source, the ping-pong
// frame buffer and a downstream consumer.
//   in_data_i/in_data_q/in_valid : input samples (no backpressure)
//   out_ready                    : downstream accepts a beat when high with out_valid
//   out_data_i/out_data_q        : output samples, 0 while out_valid is low
//   out_valid/out_sop/out_eop    : beat qualifier and frame delimiters
//   ovf_flag                     : sticky overflow indicator
// The buffer uses the slave modport; the source/sink side uses the master modport.
interface iq_frame_buffer_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] in_data_i;
    logic [DATA_WIDTH-1:0] in_data_q;
    logic                  in_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data_i;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid;
    logic                  out_sop;
    logic                  out_eop;
    logic                  ovf_flag;

    modport master (
        output in_data_i, in_data_q, in_valid, out_ready,
        input  out_data_i, out_data_q, out_valid, out_sop, out_eop, ovf_flag
    );

    modport slave (
        input  in_data_i, in_data_q, in_valid, out_ready,
        output out_data_i, out_data_q, out_valid, out_sop, out_eop, ovf_flag
    );
endinterface

// File: rtl/iq_frame_buffer.sv
// iq_frame_buffer: ping-pong IQ frame buffer. Samples are written into one of
// two FRAME_LEN-deep banks; a full bank is streamed out in address order with
// sop/eop framing while the other bank fills.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : iq_frame_buffer_if.slave (input samples, output beats, ovf_flag)
//   ovf_cnt (only with IQ_FRAME_BUFFER_OVF_CNT_EN defined): 16-bit saturating
//           count of dropped samples, cleared only by reset
module iq_frame_buffer #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 2048
) (
    input logic clk,
    input logic rst_n,
    iq_frame_buffer_if.slave bus
`ifdef IQ_FRAME_BUFFER_OVF_CNT_EN
    ,
    output logic [15:0] ovf_cnt
`endif
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    logic [2*DATA_WIDTH-1:0] r_mem [2*FRAME_LEN];
    logic [2*DATA_WIDTH-1:0] r_rd_data;
    logic [1:0]              r_full;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic                    r_ovf;
    logic [AW-1:0]           r_wr_addr;
    logic [AW-1:0]           r_beat;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic                    w_free;
    logic                    w_blocked;
    logic                    w_drop;
    logic                    w_wr_en;
    logic                    w_wr_last;
    logic                    w_cur_ready;
    logic                    w_other_ready;
    logic                    w_fetch;
    logic                    w_fetch_bank;
    logic [AW-1:0]           w_fetch_addr;
    logic [1:0]              w_clr;
    logic [1:0]              w_set;

    assign w_accept  = (r_state == STREAM) && bus.out_ready;
    assign w_free    = w_accept && (r_beat == LAST);
    // A full write bank that is being freed this very cycle accepts the sample.
    assign w_blocked = r_full[r_wr_bank] && !(w_free && (r_rd_bank == r_wr_bank));
    assign w_drop    = bus.in_valid && w_blocked;
    assign w_wr_en   = bus.in_valid && !w_blocked;
    assign w_wr_last = w_wr_en && (r_wr_addr == LAST);
    // A bank completing this cycle counts as full so reading starts one cycle earlier.
    assign w_cur_ready   = r_full[r_rd_bank] || (w_wr_last && (r_wr_bank == r_rd_bank));
    assign w_other_ready = r_full[!r_rd_bank] || (w_wr_last && (r_wr_bank != r_rd_bank));
    assign w_clr = w_free ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;

    always_comb begin
        w_state_nxt  = r_state;
        w_fetch      = 1'b0;
        w_fetch_bank = r_rd_bank;
        w_fetch_addr = r_beat + 1'b1;
        case (r_state)
            IDLE: if (w_cur_ready) w_state_nxt = PRIME;
            PRIME: begin
                w_fetch      = 1'b1;
                w_fetch_addr = '0;
                w_state_nxt  = STREAM;
            end
            STREAM: begin
                if (w_accept && !w_free) begin
                    w_fetch = 1'b1;
                end else if (w_free && w_other_ready) begin
                    // Chain straight into the next bank so back-to-back frames have no bubble.
                    w_fetch      = 1'b1;
                    w_fetch_bank = !r_rd_bank;
                    w_fetch_addr = '0;
                end else if (w_free) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_addr <= '0;
            r_beat    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= (r_full & ~w_clr) | w_set;
            if (w_wr_en) r_wr_addr <= r_wr_addr + 1'b1;
            if (w_wr_last) r_wr_bank <= !r_wr_bank;
            if (w_free) r_rd_bank <= !r_rd_bank;
            if (w_fetch) r_beat <= w_fetch_addr;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Bank storage and read register are left unreset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[{r_wr_bank, r_wr_addr}] <= {bus.in_data_q, bus.in_data_i};
        if (w_fetch) r_rd_data <= r_mem[{w_fetch_bank, w_fetch_addr}];
    end

    assign bus.out_valid  = (r_state == STREAM);
    assign bus.out_data_i = bus.out_valid ? r_rd_data[DATA_WIDTH-1:0] : '0;
    assign bus.out_data_q = bus.out_valid ? r_rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign bus.out_sop    = bus.out_valid && (r_beat == '0);
    assign bus.out_eop    = bus.out_valid && (r_beat == LAST);
    assign bus.ovf_flag   = r_ovf;

`ifdef IQ_FRAME_BUFFER_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_iq_frame_buffer.sv
// tb_iq_frame_buffer: directed self-checking bench for iq_frame_buffer with FRAME_LEN=8.
module tb_iq_frame_buffer;
    localparam int DW = 12;
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iq_frame_buffer_if #(.DATA_WIDTH(DW)) bus ();

`ifdef IQ_FRAME_BUFFER_OVF_CNT_EN
    logic [15:0] ovf_cnt;
    iq_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_cnt(ovf_cnt));
`else
    iq_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    logic [2*DW-1:0] got_d [$];
    logic [1:0]      got_se [$];
    int              got_cyc [$];

    // Record every beat that the consumer accepts on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_d.push_back({bus.out_data_q, bus.out_data_i});
            got_se.push_back({bus.out_sop, bus.out_eop});
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [2*DW-1:0] samp(input int v);
        return {DW'(v + 100), DW'(v)};
    endfunction

    task automatic push(input int v);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_data_i = DW'(v);
        bus.in_data_q = DW'(v + 100);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_d.delete();
        got_se.delete();
        got_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (got_d.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.out_valid, bus.out_sop, bus.out_eop});
        end
        checks++;
        if ({bus.out_data_q, bus.out_data_i} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.out_data_q, bus.out_data_i});
        end
        checks++;
        if (bus.ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", bus.ovf_flag);
        end
`ifdef IQ_FRAME_BUFFER_OVF_CNT_EN
        checks++;
        if (ovf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame;
        int wr_cyc;
        do_reset();
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) push(v);
        wr_cyc = cyc + 1;
        idle(1);
        wait_beats(8, 40);
        idle(5);
        checks++;
        if (got_d.size() !== 8) begin
            errors++;
            $display("FAIL single_count: got %0d expected 8", got_d.size());
        end
        for (int j = 0; j < 8 && j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== samp(j + 1)) begin
                errors++;
                $display("FAIL single_data[%0d]: got %h expected %h", j, got_d[j], samp(j + 1));
            end
            checks++;
            if (got_se[j] !== {j == 0, j == 7}) begin
                errors++;
                $display("FAIL single_sop_eop[%0d]: got %b expected %b", j, got_se[j], {j == 0, j == 7});
            end
        end
        if (got_cyc.size() > 0) begin
            checks++;
            if (got_cyc[0] - wr_cyc < 1 || got_cyc[0] - wr_cyc > 2) begin
                errors++;
                $display("FAIL single_latency: got %0d expected 1..2", got_cyc[0] - wr_cyc);
            end
        end
        checks++;
        if (bus.ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL single_ovf: got %b expected 0", bus.ovf_flag);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 24; v++) push(v);
        idle(1);
        wait_beats(24, 80);
        idle(4);
        checks++;
        if (got_d.size() !== 24) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 24", got_d.size());
        end
        for (int j = 0; j < 24 && j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== samp(j + 1) || got_se[j] !== {j % 8 == 0, j % 8 == 7}) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: got %h/%b expected %h/%b", j, got_d[j], got_se[j],
                         samp(j + 1), {j % 8 == 0, j % 8 == 7});
            end
            checks++;
            if (got_cyc[j] !== got_cyc[0] + j) begin
                errors++;
                $display("FAIL b2b_contiguous[%0d]: got cycle %0d expected %0d", j, got_cyc[j], got_cyc[0] + j);
            end
        end
        checks++;
        if (bus.ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ovf: got %b expected 0", bus.ovf_flag);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int v = 1; v <= 19; v++) push(v);
        idle(1);
        checks++;
        if (bus.ovf_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag_set: got %b expected 1", bus.ovf_flag);
        end
`ifdef IQ_FRAME_BUFFER_OVF_CNT_EN
        checks++;
        if (ovf_cnt !== 16'd3) begin
            errors++;
            $display("FAIL ovf_cnt: got %0d expected 3", ovf_cnt);
        end
`endif
        checks++;
        if (got_d.size() !== 0) begin
            errors++;
            $display("FAIL ovf_stalled_count: got %0d expected 0", got_d.size());
        end
        bus.out_ready = 1'b1;
        wait_beats(16, 60);
        idle(6);
        checks++;
        if (got_d.size() !== 16) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 16", got_d.size());
        end
        for (int j = 0; j < 16 && j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== samp(j + 1) || got_se[j] !== {j % 8 == 0, j % 8 == 7}) begin
                errors++;
                $display("FAIL ovf_beat[%0d]: got %h/%b expected %h/%b", j, got_d[j], got_se[j],
                         samp(j + 1), {j % 8 == 0, j % 8 == 7});
            end
        end
        checks++;
        if (bus.ovf_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", bus.ovf_flag);
        end
    endtask

    task automatic test_stall;
        logic            stalled = 1'b0;
        logic [2*DW+2:0] prev = '0;
        logic [2*DW+2:0] now;
        int              holds = 0;
        do_reset();
        for (int v = 1; v <= 8; v++) push(v);
        idle(1);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = (c % 2 == 0);
            @(negedge clk);
            now = {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data_q, bus.out_data_i};
            if (stalled) begin
                holds++;
                checks++;
                if (now !== prev) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got %h expected %h", c, now, prev);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev = now;
        end
        checks++;
        if (holds < 4) begin
            errors++;
            $display("FAIL stall_hold_count: got %0d expected at least 4", holds);
        end
        checks++;
        if (got_d.size() !== 8) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 8", got_d.size());
        end
        for (int j = 0; j < 8 && j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== samp(j + 1) || got_se[j] !== {j == 0, j == 7}) begin
                errors++;
                $display("FAIL stall_beat[%0d]: got %h/%b expected %h/%b", j, got_d[j], got_se[j],
                         samp(j + 1), {j == 0, j == 7});
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int v = 1; v <= 8; v++) push(v);
        for (int v = 101; v <= 105; v++) push(v);
        idle(1);
        checks++;
        if ({bus.out_valid, bus.out_sop} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre_valid: got %b expected 11", {bus.out_valid, bus.out_sop});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.ovf_flag} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_flags: got %b expected 0000",
                     {bus.out_valid, bus.out_sop, bus.out_eop, bus.ovf_flag});
        end
        checks++;
        if ({bus.out_data_q, bus.out_data_i} !== '0) begin
            errors++;
            $display("FAIL mid_rst_data: got %h expected 0", {bus.out_data_q, bus.out_data_i});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_d.delete();
        got_se.delete();
        got_cyc.delete();
        bus.out_ready = 1'b1;
        for (int v = 201; v <= 208; v++) push(v);
        idle(1);
        wait_beats(8, 40);
        idle(6);
        checks++;
        if (got_d.size() !== 8) begin
            errors++;
            $display("FAIL mid_count: got %0d expected 8", got_d.size());
        end
        for (int j = 0; j < 8 && j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== samp(j + 201) || got_se[j] !== {j == 0, j == 7}) begin
                errors++;
                $display("FAIL mid_beat[%0d]: got %h/%b expected %h/%b", j, got_d[j], got_se[j],
                         samp(j + 201), {j == 0, j == 7});
            end
        end
    endtask

    task automatic test_coincide;
        int k = 0;
        int hit_cyc;
        do_reset();
        for (int v = 1; v <= 15; v++) push(v);
        bus.out_ready = 1'b1;
        idle(1);
        while (got_d.size() < 7 && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got_d.size() !== 7) begin
            errors++;
            $display("FAIL coin_pre_count: got %0d expected 7", got_d.size());
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data_i = DW'(16);
        bus.in_data_q = DW'(116);
        hit_cyc = cyc;
        for (int v = 17; v <= 24; v++) push(v);
        idle(1);
        wait_beats(24, 80);
        idle(4);
        checks++;
        if (got_d.size() !== 24) begin
            errors++;
            $display("FAIL coin_count: got %0d expected 24", got_d.size());
        end
        if (got_cyc.size() > 7) begin
            checks++;
            if (got_cyc[7] !== hit_cyc) begin
                errors++;
                $display("FAIL coin_eop_cycle: got %0d expected %0d", got_cyc[7], hit_cyc);
            end
        end
        for (int j = 0; j < 24 && j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== samp(j + 1) || got_se[j] !== {j % 8 == 0, j % 8 == 7}) begin
                errors++;
                $display("FAIL coin_beat[%0d]: got %h/%b expected %h/%b", j, got_d[j], got_se[j],
                         samp(j + 1), {j % 8 == 0, j % 8 == 7});
            end
        end
        checks++;
        if (bus.ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL coin_ovf: got %b expected 0", bus.ovf_flag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data_i = '0;
        bus.in_data_q = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_coincide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
